// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - single-port framebuffer arbiter between VGA display fetch and buffered host writes
module vga_fb_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_WORDS   = 19200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        de,
   input  logic        host_valid,
   input  logic [14:0] host_addr,
   input  logic [11:0] host_data,
   output logic        host_ready,
   output logic [14:0] mem_addr,
   output logic        mem_we,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        de_out,
   output logic        addr_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [14:0]   FB_LAST    = 15'(FB_WORDS - 1);

   // host write queue storage, {addr,data} per entry
   logic [14:0] fifo_addr_q [FIFO_DEPTH];
   logic [11:0] fifo_data_q [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   logic          slot_q;
   logic          de1_q, de2_q;
   logic [11:0]   pix_q;
   logic          err_q;

   logic [14:0] ycell, xcell, cell_addr;
   logic        slot, push, pop, head_ok;
   logic [14:0] head_addr;
   logic [11:0] head_data;

   // cell address (y>>2)*160 + (x>>2) built from shifts: 160 = 128 + 32
   assign ycell     = {6'd0, y[10:2]};
   assign xcell     = {6'd0, x[10:2]};
   assign cell_addr = (ycell << 7) + (ycell << 5) + xcell;

   // a display slot owns the memory port outright; writes fill every other cycle
   assign slot      = de && (x[1:0] == 2'b00);
   assign push      = host_valid && ready_q;
   assign pop       = !slot && (count_q != '0);
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_data = fifo_data_q[rd_ptr_q];
   assign head_ok   = (head_addr <= FB_LAST);

   // occupancy and the registered ready that follows it
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      ready_d = (count_d != FULL_COUNT);
   end

   // memory port mux: display read, queued write, or idle zeros; forced idle in reset
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 15'd0;
      mem_wdata = 12'd0;
      if (!rst) begin
         if (slot) begin
            mem_addr = cell_addr;
         end else if (pop && head_ok) begin
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
         end
      end
   end

   // entry storage needs no reset; pointers and count decide what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= host_addr;
         fifo_data_q[wr_ptr_q] <= host_data;
      end
   end

   // queue control, display pipeline and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         slot_q   <= 1'b0;
         de1_q    <= 1'b0;
         de2_q    <= 1'b0;
         pix_q    <= 12'd0;
         err_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         ready_q <= ready_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            if (!head_ok) begin
               err_q <= 1'b1;
            end
         end
         // memory returns read data one cycle after the slot; capture it then
         slot_q <= slot;
         if (slot_q) begin
            pix_q <= mem_rdata;
         end
         de1_q <= de;
         de2_q <= de1_q;
      end
   end

   assign host_ready = ready_q;
   assign de_out     = de2_q;
   assign r          = de2_q ? pix_q[11:8] : 4'h0;
   assign g          = de2_q ? pix_q[7:4]  : 4'h0;
   assign b          = de2_q ? pix_q[3:0]  : 4'h0;
   assign addr_err   = err_q;

endmodule
